// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

   // Default operand width when the instantiating block does not override it.
   localparam int SERIAL_SUB_DEFAULT_WIDTH = 4;

   // Control states: waiting for a request, or shifting bits through the cell.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   // Borrow when b exceeds a outright, or when they are equal and a borrow arrives.
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: Diff = A - B - Bin, one bit per clock,
// LSB first, start/done handshake. A single full_subtractor cell is reused every
// cycle, with the inter-bit borrow held in a flop.
// Optional feature: define SERIAL_SUB_OVF_EN to add the Ovf port (signed overflow).
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = SERIAL_SUB_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             Ovf
`endif
);

   localparam int              CNT_W    = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_sr_q, a_sr_d;
   logic [WIDTH-1:0]   b_sr_q, b_sr_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               bor_q, bor_d;
   logic               bout_q, bout_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;
`ifdef SERIAL_SUB_OVF_EN
   logic               ovf_q, ovf_d;
`endif

   logic               cell_d;
   logic               cell_bo;

   full_subtractor u_cell (
      .a    (a_sr_q[0]),
      .b    (b_sr_q[0]),
      .bin  (bor_q),
      .d    (cell_d),
      .bout (cell_bo)
   );

   // Next-state logic: capture operands on an accepted start, then shift one bit per cycle.
   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      diff_d  = diff_q;
      cnt_d   = cnt_q;
      bor_d   = bor_q;
      bout_d  = bout_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               a_sr_d  = A;
               b_sr_d  = B;
               bor_d   = Bin;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
            diff_d = {cell_d, diff_q[WIDTH-1:1]};
            bor_d  = cell_bo;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
               bout_d  = cell_bo;
`ifdef SERIAL_SUB_OVF_EN
               // Signed overflow: borrow into the sign bit differs from borrow out of it.
               ovf_d   = bor_q ^ cell_bo;
`endif
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         bor_q   <= 1'b0;
         bout_q  <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         bor_q   <= bor_d;
         bout_q  <= bout_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign Diff = diff_q;
   assign Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
   assign Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH = 4).
module tb_serial_subtractor;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         Bin = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] Diff;
   logic         Bout;
`ifdef SERIAL_SUB_OVF_EN
   logic         Ovf;
`endif

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .Bin   (Bin),
      .busy  (busy),
      .done  (done),
      .Diff  (Diff),
      .Bout  (Bout)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .Ovf   (Ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] diff;
      logic         bout;
      logic         ovf;
      int           acc;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] diff;
      logic         bout;
   } vec_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   bit   burst    = 0;
   int   last_done = -1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
      exp_t         m;
      logic [W:0]   t;
      int           sd;
      t      = {1'b0, a} - {1'b0, b} - (W+1)'(bi);
      m.a    = a;
      m.b    = b;
      m.bin  = bi;
      m.diff = t[W-1:0];
      m.bout = t[W];
      sd     = int'($signed(a)) - int'($signed(b)) - int'(bi);
      m.ovf  = (sd > (1 << (W-1)) - 1) || (sd < -(1 << (W-1)));
      m.acc  = 0;
      return m;
   endfunction

   // Monitor: pops the expected result whenever done is presented.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && done) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done: got done=1 want no pending op (cycle %0d)", cyc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               $display("op A=%b B=%b Bin=%b -> Diff=%b Bout=%b (want %b %b)",
                        e.a, e.b, e.bin, Diff, Bout, e.diff, e.bout);
               chk("diff", 32'(Diff), 32'(e.diff));
               chk("bout", 32'(Bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
               chk("ovf", 32'(Ovf), 32'(e.ovf));
`endif
               chk("latency", 32'(cyc - e.acc), 32'(W));
               chk("busy_at_done", 32'(busy), 32'd0);
            end
            if (burst && last_done >= 0)
               chk("done_interval", 32'(cyc - last_done), 32'(W + 1));
            last_done = cyc;
         end
      end
   end

   task automatic issue_raw(input exp_t e);
      int guard = 0;
      @(negedge clk);
      while (busy && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (busy) begin
         checks++;
         failures++;
         $display("FAIL busy_timeout: got busy=1 want 0 within 50 cycles");
      end
      A     = e.a;
      B     = e.b;
      Bin   = e.bin;
      start = 1'b1;
      e.acc = cyc + 1;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      A     = ~A;
      B     = ~B;
      chk("busy_after_accept", 32'(busy), 32'd1);
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
      issue_raw(model(a, b, bi));
   endtask

   task automatic drain();
      int guard = 0;
      while (exp_q.size() != 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_diff"}, 32'(Diff), 32'd0);
      chk({tag, "_bout"}, 32'(Bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      chk({tag, "_ovf"}, 32'(Ovf), 32'd0);
`endif
   endtask

   vec_t vecs[5] = '{
      '{4'b0110, 4'b1100, 1'b0, 4'b1010, 1'b1},
      '{4'b0110, 4'b1100, 1'b1, 4'b1001, 1'b1},
      '{4'b1110, 4'b1000, 1'b0, 4'b0110, 1'b0},
      '{4'b0111, 4'b1110, 1'b0, 4'b1001, 1'b1},
      '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1}
   };

   initial begin
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Directed vectors with hand-written Diff/Bout.
      foreach (vecs[i]) begin
         exp_t e;
         e      = model(vecs[i].a, vecs[i].b, vecs[i].bin);
         e.diff = vecs[i].diff;
         e.bout = vecs[i].bout;
         issue_raw(e);
      end
      drain();

      // start held high with operands changing every cycle.
      burst     = 1;
      last_done = -1;
      for (int i = 0; i < 26; i++) begin
         @(negedge clk);
         A     = W'($urandom);
         B     = W'($urandom);
         Bin   = 1'($urandom);
         start = 1'b1;
         if (!busy) begin
            exp_t e;
            e     = model(A, B, Bin);
            e.acc = cyc + 1;
            exp_q.push_back(e);
         end
      end
      @(negedge clk);
      start = 1'b0;
      drain();
      burst = 0;

      // Reset while bit 2 is in progress.
      issue(W'($urandom), W'($urandom), 1'($urandom));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check_outputs_zero("midrst");
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (W + 2) @(negedge clk);
      chk("no_done_after_abort", 32'(done), 32'd0);
      issue(4'b0101, 4'b0011, 1'b1);
      drain();

      // Full sweep of every operand combination, in random order.
      begin
         int order[512];
         for (int i = 0; i < 512; i++) order[i] = i;
         for (int i = 511; i > 0; i--) begin
            int j;
            int t;
            j        = int'($urandom_range(i, 0));
            t        = order[i];
            order[i] = order[j];
            order[j] = t;
         end
         for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(order[i]);
            issue(v[8:5], v[4:1], v[0]);
         end
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
